// File: rtl/frame_tail_tx_if.sv
// Bus between the bit-stream transmitter and the CAN frame-tail sequencer.
// The master requests the tail and supplies bus timing; the slave sequences it.
interface frame_tail_tx_if;
   logic SP;
   logic RX;
   logic Start;
   logic TX;
   logic Busy;
   logic EOF_Flag;
   logic Done;
   logic ACK_Error;
   logic Form_Error;
   logic Overload;

   modport master (
      output SP, RX, Start,
      input  TX, Busy, EOF_Flag, Done, ACK_Error, Form_Error, Overload
   );

   modport slave (
      input  SP, RX, Start,
      output TX, Busy, EOF_Flag, Done, ACK_Error, Form_Error, Overload
   );
endinterface

// File: rtl/frame_tail_tx.sv
// CAN transmit-side frame tail: CRC delimiter, ACK slot/delimiter, EOF and
// intermission, with acknowledge, form-error and overload monitoring on RX.
module frame_tail_tx #(
   parameter int EOF_BITS = 7,
   parameter int IFS_BITS = 3
) (
   input logic            clock,
   input logic            reset,
   frame_tail_tx_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CRC_DEL,
      S_ACK_SLOT,
      S_ACK_DEL,
      S_EOF,
      S_IFS
   } state_t;

   localparam logic [3:0] EOF_LAST = 4'(EOF_BITS - 1);
   localparam logic [3:0] IFS_LAST = 4'(IFS_BITS - 1);

   state_t     r_state;
   logic [3:0] r_cont;
   logic       r_tx;
   logic       r_busy;
   logic       r_eofFlag;
   logic       r_done;
   logic       r_ackError;
   logic       r_formError;
   logic       r_overload;

   // Pulses default low each clock; any exit to IDLE also drops Busy and EOF_Flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cont      <= '0;
         r_tx        <= 1'b1;
         r_busy      <= 1'b0;
         r_eofFlag   <= 1'b1;
         r_done      <= 1'b0;
         r_ackError  <= 1'b0;
         r_formError <= 1'b0;
         r_overload  <= 1'b0;
      end else begin
         r_tx        <= 1'b1;
         r_done      <= 1'b0;
         r_ackError  <= 1'b0;
         r_formError <= 1'b0;
         r_overload  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.Start) begin
                  r_state <= S_CRC_DEL;
                  r_cont  <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_CRC_DEL: begin
               if (bus.SP) begin
                  if (!bus.RX) begin
                     r_formError <= 1'b1;
                     r_state     <= S_IDLE;
                     r_busy      <= 1'b0;
                  end else begin
                     r_state <= S_ACK_SLOT;
                  end
               end
            end
            S_ACK_SLOT: begin
               if (bus.SP) begin
                  if (bus.RX) begin
                     r_ackError <= 1'b1;
                     r_state    <= S_IDLE;
                     r_busy     <= 1'b0;
                  end else begin
                     r_state <= S_ACK_DEL;
                  end
               end
            end
            S_ACK_DEL: begin
               if (bus.SP) begin
                  if (!bus.RX) begin
                     r_formError <= 1'b1;
                     r_state     <= S_IDLE;
                     r_busy      <= 1'b0;
                  end else begin
                     r_state   <= S_EOF;
                     r_cont    <= '0;
                     r_eofFlag <= 1'b0;
                  end
               end
            end
            S_EOF: begin
               if (bus.SP) begin
                  if (!bus.RX) begin
                     r_formError <= 1'b1;
                     r_state     <= S_IDLE;
                     r_busy      <= 1'b0;
                     r_eofFlag   <= 1'b1;
                  end else if (r_cont == EOF_LAST) begin
                     r_done    <= 1'b1;
                     r_state   <= S_IFS;
                     r_cont    <= '0;
                     r_eofFlag <= 1'b1;
                  end else begin
                     r_cont <= r_cont + 4'd1;
                  end
               end
            end
            S_IFS: begin
               // Done has already been issued, so a dominant bit here is overload, not error.
               if (bus.SP) begin
                  if (!bus.RX) begin
                     r_overload <= 1'b1;
                     r_state    <= S_IDLE;
                     r_busy     <= 1'b0;
                  end else if (r_cont == IFS_LAST) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_cont <= r_cont + 4'd1;
                  end
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_busy    <= 1'b0;
               r_eofFlag <= 1'b1;
            end
         endcase
      end
   end

   assign bus.TX         = r_tx;
   assign bus.Busy       = r_busy;
   assign bus.EOF_Flag   = r_eofFlag;
   assign bus.Done       = r_done;
   assign bus.ACK_Error  = r_ackError;
   assign bus.Form_Error = r_formError;
   assign bus.Overload   = r_overload;

endmodule
